fft_frame_ctrl: RTL and testbench

Frame sequencer for the decimate → window → fft8k chain, clocked on `fft_clk`. It accepts the decimated sample strobe and frames it into N-point FFT input packets, producing `sink_sop`/`sink_eop`/`sink_valid` and the window-ROM sample index while honouring the FFT core's `sink_ready`. It runs either a fixed burst of frames or continuously. It also tracks completed FFT output frames, so that software on the NIOS side knows when every spectrum of a burst has left the core.

---
 rtl/fft_frame_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame sequencer for the decimate -> window -> fft8k chain.
//
// Frames the decimated sample strobe into N = 2**FFT_LOG2 point FFT input packets.
// It runs either a burst of nframes frames or continuously until stop. It also
// counts returned FFT output frames, so a burst reports done only once every
// spectrum has left the core.
//
// Optional build macro: FFT_FRAME_CTRL_GAP_EN adds the gap_len input and a GAP
// state. GAP discards gap_len sample_valid pulses between frames.
//
// Ports (all on fft_clk rising edge, reset_n async active-low):
//   start, stop, continuous, nframes   run control (sampled on start in IDLE)
//   gap_len                            inter-frame gap in samples (GAP build only)
//   sample_valid, sink_ready           sample strobe and FFT core backpressure
//   source_valid, source_eop           FFT output, used to count drained frames
//   sink_valid/sop/eop, win_addr       registered FFT input framing and window index
//   busy, done, frames_in, drop_err    status
module fft_frame_ctrl #(
  parameter int unsigned FFT_LOG2 = 13,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                fft_clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic                continuous,
  input  logic [CNT_W-1:0]    nframes,
`ifdef FFT_FRAME_CTRL_GAP_EN
  input  logic [15:0]         gap_len,
`endif
  input  logic                sample_valid,
  input  logic                sink_ready,
  input  logic                source_valid,
  input  logic                source_eop,
  output logic                sink_valid,
  output logic                sink_sop,
  output logic                sink_eop,
  output logic [FFT_LOG2-1:0] win_addr,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    frames_in,
  output logic                drop_err
);

  localparam logic [FFT_LOG2-1:0] LastIdx = '1;
  localparam logic [FFT_LOG2-1:0] IdxOne  = FFT_LOG2'(1);
  localparam logic [CNT_W-1:0]    CntOne  = CNT_W'(1);

`ifdef FFT_FRAME_CTRL_GAP_EN
  localparam logic [15:0] GapOne = 16'd1;
  typedef enum logic [2:0] {StIdle, StWait, StStream, StGap, StDrain} state_e;
`else
  typedef enum logic [2:0] {StIdle, StWait, StStream, StDrain} state_e;
`endif

  state_e               state_q, state_d;
  logic                 cont_q, cont_d;
  logic [CNT_W-1:0]     nframes_q, nframes_d;
  logic [CNT_W-1:0]     frames_in_q, frames_in_d;
  logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
  logic                 drop_err_q, drop_err_d;
  logic                 stop_pend_q, stop_pend_d;
  logic [FFT_LOG2-1:0]  idx_q, idx_d;
  logic                 sink_valid_q, sink_valid_d;
  logic                 sink_sop_q, sink_sop_d;
  logic                 sink_eop_q, sink_eop_d;
  logic [FFT_LOG2-1:0]  win_addr_q, win_addr_d;
  logic                 done_q, done_d;
`ifdef FFT_FRAME_CTRL_GAP_EN
  logic [15:0]          gap_len_q, gap_len_d;
  logic [15:0]          gap_cnt_q, gap_cnt_d;
`endif

  logic                 accept;
  logic                 stop_now;
  logic                 src_eop;
  logic                 to_drain;
  logic [CNT_W-1:0]     frames_next;

  assign accept   = sample_valid & sink_ready;
  // A stop arriving this very cycle counts as pending; burst mode never pends.
  assign stop_now = stop_pend_q | (stop & cont_q);
  assign src_eop  = source_valid & source_eop;

  always_comb begin
    state_d      = state_q;
    cont_d       = cont_q;
    nframes_d    = nframes_q;
    frames_in_d  = frames_in_q;
    out_cnt_d    = out_cnt_q;
    drop_err_d   = drop_err_q;
    stop_pend_d  = stop_pend_q;
    idx_d        = idx_q;
    sink_valid_d = 1'b0;
    sink_sop_d   = 1'b0;
    sink_eop_d   = 1'b0;
    win_addr_d   = win_addr_q;
    done_d       = 1'b0;
    to_drain     = 1'b0;
    frames_next  = frames_in_q + CntOne;
`ifdef FFT_FRAME_CTRL_GAP_EN
    gap_len_d    = gap_len_q;
    gap_cnt_d    = gap_cnt_q;
`endif

    if (state_q != StIdle) begin
      if (src_eop) begin
        out_cnt_d = out_cnt_q + CntOne;
      end
      if (stop && cont_q) begin
        stop_pend_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cont_d      = continuous;
          nframes_d   = nframes;
          frames_in_d = '0;
          out_cnt_d   = '0;
          drop_err_d  = 1'b0;
          stop_pend_d = 1'b0;
          idx_d       = '0;
`ifdef FFT_FRAME_CTRL_GAP_EN
          gap_len_d   = gap_len;
`endif
          state_d     = StWait;
        end
      end

      StWait: begin
        if (stop_now) begin
          to_drain = 1'b1;
        end else if (accept) begin
          sink_valid_d = 1'b1;
          sink_sop_d   = 1'b1;
          win_addr_d   = '0;
          idx_d        = IdxOne;
          state_d      = StStream;
        end
      end

      StStream: begin
        if (sample_valid && !sink_ready) begin
          // Dropped mid-frame: index holds so the packet still has N beats.
          drop_err_d = 1'b1;
        end else if (accept) begin
          sink_valid_d = 1'b1;
          win_addr_d   = idx_q;
          if (idx_q == LastIdx) begin
            sink_eop_d  = 1'b1;
            frames_in_d = frames_next;
            idx_d       = '0;
            // nframes == 0 matches once frames_in wraps back to 0.
            if (cont_q ? stop_now : (frames_next == nframes_q)) begin
              to_drain = 1'b1;
            end else begin
`ifdef FFT_FRAME_CTRL_GAP_EN
              gap_cnt_d = '0;
              state_d   = StGap;
`else
              state_d   = StWait;
`endif
            end
          end else begin
            idx_d = idx_q + IdxOne;
          end
        end
      end

`ifdef FFT_FRAME_CTRL_GAP_EN
      StGap: begin
        if (stop_now) begin
          to_drain = 1'b1;
        end else if (gap_len_q == '0) begin
          state_d = StWait;
        end else if (sample_valid) begin
          // Leave on the last discarded pulse so the next one is usable.
          if (gap_cnt_q + GapOne == gap_len_q) begin
            state_d = StWait;
          end else begin
            gap_cnt_d = gap_cnt_q + GapOne;
          end
        end
      end
`endif

      StDrain: begin
        to_drain = 1'b1;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Compare on updated counts so a same-cycle source_eop is accounted for.
    if (to_drain) begin
      if (out_cnt_d == frames_in_d) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end else begin
        state_d = StDrain;
      end
    end
  end

  always_ff @(posedge fft_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cont_q       <= 1'b0;
      nframes_q    <= '0;
      frames_in_q  <= '0;
      out_cnt_q    <= '0;
      drop_err_q   <= 1'b0;
      stop_pend_q  <= 1'b0;
      idx_q        <= '0;
      sink_valid_q <= 1'b0;
      sink_sop_q   <= 1'b0;
      sink_eop_q   <= 1'b0;
      win_addr_q   <= '0;
      done_q       <= 1'b0;
`ifdef FFT_FRAME_CTRL_GAP_EN
      gap_len_q    <= '0;
      gap_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cont_q       <= cont_d;
      nframes_q    <= nframes_d;
      frames_in_q  <= frames_in_d;
      out_cnt_q    <= out_cnt_d;
      drop_err_q   <= drop_err_d;
      stop_pend_q  <= stop_pend_d;
      idx_q        <= idx_d;
      sink_valid_q <= sink_valid_d;
      sink_sop_q   <= sink_sop_d;
      sink_eop_q   <= sink_eop_d;
      win_addr_q   <= win_addr_d;
      done_q       <= done_d;
`ifdef FFT_FRAME_CTRL_GAP_EN
      gap_len_q    <= gap_len_d;
      gap_cnt_q    <= gap_cnt_d;
`endif
    end
  end

  assign sink_valid = sink_valid_q;
  assign sink_sop   = sink_sop_q;
  assign sink_eop   = sink_eop_q;
  assign win_addr   = win_addr_q;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign frames_in  = frames_in_q;
  assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Testbench for fft_frame_ctrl with N = 16 and 3-bit frame counters.
// A vector table drives whole runs (burst, continuous, stop, drops, wrap, gap)
// and checks beat count, framing, status and drain timing. Hand-written
// sequences then cover reset behaviour.
module tb_fft_frame_ctrl;

  localparam int unsigned Log2     = 4;
  localparam int unsigned CntW     = 3;
  localparam int          N        = 16;
  localparam int          FftDelay = 40;
`ifdef FFT_FRAME_CTRL_GAP_EN
  localparam int          GapVal   = 10;
`else
  localparam int          GapVal   = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic            continuous = 1'b0;
  logic [CntW-1:0] nframes = '0;
`ifdef FFT_FRAME_CTRL_GAP_EN
  logic [15:0]     gap_len = '0;
`endif
  logic            sample_valid = 1'b0;
  logic            sink_ready = 1'b1;
  logic            source_valid = 1'b0;
  logic            source_eop = 1'b0;
  logic            sink_valid, sink_sop, sink_eop, busy, done, drop_err;
  logic [Log2-1:0] win_addr;
  logic [CntW-1:0] frames_in;

  fft_frame_ctrl #(.FFT_LOG2(Log2), .CNT_W(CntW)) dut (
    .fft_clk      (clk),
    .reset_n      (rst_n),
    .start        (start),
    .stop         (stop),
    .continuous   (continuous),
    .nframes      (nframes),
`ifdef FFT_FRAME_CTRL_GAP_EN
    .gap_len      (gap_len),
`endif
    .sample_valid (sample_valid),
    .sink_ready   (sink_ready),
    .source_valid (source_valid),
    .source_eop   (source_eop),
    .sink_valid   (sink_valid),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .win_addr     (win_addr),
    .busy         (busy),
    .done         (done),
    .frames_in    (frames_in),
    .drop_err     (drop_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Beat monitor: framing/index continuity, beat and done bookkeeping.
  int beats = 0, mon_err = 0, exp_addr = 0;
  int done_cnt = 0, done_cyc = 0, busy_at_done = 0;
  int gap_pulses = 0, last_gap = -1;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_addr = 0;
    end else begin
      if (sink_valid) begin
        beats++;
        if (int'(win_addr) != exp_addr || sink_sop != (exp_addr == 0) ||
            sink_eop != (exp_addr == N - 1)) mon_err++;
        if (sink_sop) last_gap = gap_pulses - 1;
        if (sink_eop) gap_pulses = 0;
        exp_addr = (exp_addr + 1) % N;
      end else if (sink_sop || sink_eop) begin
        mon_err++;
      end
      if (sample_valid) gap_pulses++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = int'(busy);
      end
    end
  end

  // FFT core model: returns one source_eop FftDelay cycles after each sink_eop.
  int due_q[$];
  int src_cnt = 0, src_cyc = 0;
  initial forever begin
    @(negedge clk);
    source_valid = 1'b0;
    source_eop   = 1'b0;
    if (!rst_n) begin
      due_q.delete();
    end else begin
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        void'(due_q.pop_front());
        source_valid = 1'b1;
        source_eop   = 1'b1;
        src_cnt++;
        src_cyc = cyc;
      end
      if (sink_valid && sink_eop) due_q.push_back(cyc + FftDelay);
    end
  end

  typedef struct {
    int   period;      // cycles between sample_valid pulses
    logic cont;
    int   nfr;
    int   stop_at;     // accepted-sample ordinal carrying a stop pulse (-1: none)
    logic start_stop;  // stop asserted together with start
    int   drop_at;     // ordinal preceded by drop_n sink_ready=0 pulses
    int   drop_n;
    int   gap;
    logic chk_gap;
    int   exp_frames;
    int   exp_fin;
    logic exp_drop;
    int   exp_gap;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input int k);
    int sent = 0, drops_left = v.drop_n, phase = 0, waited = 0;
    int b0 = beats, e0 = mon_err, d0 = done_cnt, s0 = src_cnt;
    string p = $sformatf("v%0d_", k);
    @(posedge clk); #1;
    start      = 1'b1;
    continuous = v.cont;
    nframes    = CntW'(v.nfr);
    stop       = v.start_stop;
`ifdef FFT_FRAME_CTRL_GAP_EN
    gap_len    = 16'(v.gap);
`endif
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    while (done_cnt == d0 && waited < 3000) begin
      sample_valid = 1'b0;
      sink_ready   = 1'b1;
      stop         = 1'b0;
      if (phase == 0) begin
        sample_valid = 1'b1;
        if (sent == v.drop_at && drops_left > 0) begin
          sink_ready = 1'b0;
          drops_left--;
        end else begin
          if (sent == v.stop_at) stop = 1'b1;
          sent++;
        end
      end
      phase = (phase + 1) % v.period;
      @(posedge clk); #1;
      waited++;
    end
    sample_valid = 1'b0;
    stop         = 1'b0;
    sink_ready   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check({p, "done_pulses"}, done_cnt - d0, 1);
    check({p, "beats"}, beats - b0, v.exp_frames * N);
    check({p, "framing_errors"}, mon_err - e0, 0);
    check({p, "frames_in"}, int'(frames_in), v.exp_fin);
    check({p, "drop_err"}, int'(drop_err), int'(v.exp_drop));
    check({p, "busy_at_done"}, busy_at_done, 0);
    check({p, "busy_after"}, int'(busy), 0);
    check({p, "source_eops"}, src_cnt - s0, v.exp_frames);
    check({p, "done_latency"}, done_cyc - src_cyc, 1);
    if (v.chk_gap) check({p, "gap_pulses"}, last_gap, v.exp_gap);
  endtask

  initial begin
    // period cont nfr stop_at st_stop drop_at drop_n gap chk_gap frames fin drop gap_exp
    vecs[0] = '{3, 1'b0, 2, 5,  1'b0, -1, 0, 0,  1'b0, 2, 2, 1'b0, 0};      // stop ignored
    vecs[1] = '{3, 1'b0, 2, -1, 1'b0, 6,  5, 0,  1'b0, 2, 2, 1'b1, 0};      // 5 drops
    vecs[2] = '{2, 1'b1, 0, 55, 1'b1, -1, 0, 0,  1'b0, 4, 4, 1'b0, 0};      // stop in frame 3
    vecs[3] = '{1, 1'b0, 0, -1, 1'b0, -1, 0, 0,  1'b0, 8, 0, 1'b0, 0};      // nframes=0 wrap
    vecs[4] = '{1, 1'b1, 0, 16, 1'b0, -1, 0, 0,  1'b0, 1, 1, 1'b0, 0};      // stop between frames
    vecs[5] = '{4, 1'b0, 1, -1, 1'b0, 15, 2, 0,  1'b0, 1, 1, 1'b1, 0};      // drops at last idx
    vecs[6] = '{3, 1'b0, 2, -1, 1'b0, -1, 0, 10, 1'b1, 2, 2, 1'b0, GapVal}; // gap

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          int'({sink_valid, sink_sop, sink_eop, busy, done, drop_err, win_addr, frames_in}), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_release", int'(busy), 0);

    for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

    // Mid-frame asynchronous reset, then a clean restart from index 0.
    @(posedge clk); #1;
    start = 1'b1; continuous = 1'b0; nframes = CntW'(2);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      sample_valid = 1'b1;
      sink_ready   = (i != 3);
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
    sink_ready   = 1'b1;
    check("pre_reset_addr", int'(win_addr), 7);
    check("pre_reset_valid", int'(sink_valid), 1);
    check("pre_reset_drop", int'(drop_err), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          int'({sink_valid, sink_sop, sink_eop, busy, done, drop_err, win_addr, frames_in}), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_busy", int'(busy), 0);
    start = 1'b1; continuous = 1'b0; nframes = CntW'(1);
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_busy", int'(busy), 1);
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    check("restart_beat", int'({sink_valid, sink_sop, sink_eop}), 6);
    check("restart_addr", int'(win_addr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
